// File: rtl/schedule_player.sv
// ---------------------------------------------------------------------------
// schedule_player
//
// Replays a finished DRAM command schedule out of schedule_memory. There is
// one slot per transfer, from slot 0 through the captured max_cycle. The
// player drives the memory's synchronous read address, absorbs its one-cycle
// read latency, and presents each slot on a valid/ready command port. Every
// slot is delivered, DESELECT included. PHY back-pressure therefore stretches
// the timeline but keeps the relative spacing between commands.
//
// Optional feature (macro SCHED_PLAYER_STATS_EN):
//   When defined, act_count / rd_count / pre_count count accepted ACT / RD /
//   PRE slots. They clear on an accepted start and saturate at all-ones.
//   When undefined, the ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   start                 one-cycle pulse, begins playback (IDLE only)
//   abort                 synchronous abort, highest priority
//   sched_max_cycle       last populated slot of the schedule
//   mem_rd_cycle          read address to schedule_memory (combinational)
//   mem_rd_*              registered read data from schedule_memory
//   cmd_valid/cmd_ready   command port handshake toward the PHY driver
//   cmd_cycle, cmd_*      schedule index and payload of the presented slot
//   busy                  high while priming or playing (registered)
//   done                  one-cycle pulse on normal completion
//   act/rd/pre_count      per-type statistics
//
// Field widths and command encodings mirror dram_scheduler_types.vh and are
// exposed as parameters so that this file stands alone.
// ---------------------------------------------------------------------------
module schedule_player #(
    parameter int STAT_WIDTH  = 16,
    parameter int CYCLE_WIDTH = 10,
    parameter int CMD_WIDTH   = 3,
    parameter int BG_WIDTH    = 2,
    parameter int BANK_WIDTH  = 2,
    parameter int ROW_WIDTH   = 16,
    parameter int COL_WIDTH   = 10,
    parameter int ID_WIDTH    = 8,
    parameter logic [CMD_WIDTH-1:0] CMD_DESELECT = 3'd0,
    parameter logic [CMD_WIDTH-1:0] CMD_ACT      = 3'd1,
    parameter logic [CMD_WIDTH-1:0] CMD_RD       = 3'd2,
    parameter logic [CMD_WIDTH-1:0] CMD_PRE      = 3'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CYCLE_WIDTH-1:0] sched_max_cycle,
    output logic [CYCLE_WIDTH-1:0] mem_rd_cycle,
    input  logic [CMD_WIDTH-1:0]   mem_rd_cmd_type,
    input  logic [BG_WIDTH-1:0]    mem_rd_bank_group,
    input  logic [BANK_WIDTH-1:0]  mem_rd_bank,
    input  logic [ROW_WIDTH-1:0]   mem_rd_row,
    input  logic [COL_WIDTH-1:0]   mem_rd_column,
    input  logic [ID_WIDTH-1:0]    mem_rd_request_id,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [CYCLE_WIDTH-1:0] cmd_cycle,
    output logic [CMD_WIDTH-1:0]   cmd_type,
    output logic [BG_WIDTH-1:0]    cmd_bank_group,
    output logic [BANK_WIDTH-1:0]  cmd_bank,
    output logic [ROW_WIDTH-1:0]   cmd_row,
    output logic [COL_WIDTH-1:0]   cmd_column,
    output logic [ID_WIDTH-1:0]    cmd_request_id,
    output logic                   busy,
    output logic                   done,
    output logic [STAT_WIDTH-1:0]  act_count,
    output logic [STAT_WIDTH-1:0]  rd_count,
    output logic [STAT_WIDTH-1:0]  pre_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CYCLE_WIDTH-1:0] PTR_ONE = 1;

    state_t                 state_reg;
    logic [CYCLE_WIDTH-1:0] ptr_reg;
    logic [CYCLE_WIDTH-1:0] end_cycle_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic in_play;
    logic xfer;
    logic at_end;
    logic start_ok;

    assign in_play  = (state_reg == ST_PLAY);
    // Abort suppresses valid in the same cycle, so no slot is accepted then.
    assign cmd_valid = in_play & ~abort;
    assign xfer      = cmd_valid & cmd_ready;
    assign at_end    = (ptr_reg == end_cycle_reg);
    assign start_ok  = (state_reg == ST_IDLE) & start & ~abort;

    assign busy = busy_reg;
    assign done = done_reg;

    // The read address points one slot ahead only when the current slot is
    // being accepted. On a stall the memory re-reads the same slot, so the
    // payload stays stable. On the last slot the address stays put, so the
    // pointer never wraps past max_cycle.
    always_comb begin
        mem_rd_cycle = '0;
        if (in_play) begin
            if (xfer && !at_end) begin
                mem_rd_cycle = ptr_reg + PTR_ONE;
            end else begin
                mem_rd_cycle = ptr_reg;
            end
        end
    end

    // Payload passes straight through from memory during PLAY. Otherwise the
    // port idles at DESELECT with every other field at zero.
    always_comb begin
        cmd_cycle      = '0;
        cmd_type       = CMD_DESELECT;
        cmd_bank_group = '0;
        cmd_bank       = '0;
        cmd_row        = '0;
        cmd_column     = '0;
        cmd_request_id = '0;
        if (in_play) begin
            cmd_cycle      = ptr_reg;
            cmd_type       = mem_rd_cmd_type;
            cmd_bank_group = mem_rd_bank_group;
            cmd_bank       = mem_rd_bank;
            cmd_row        = mem_rd_row;
            cmd_column     = mem_rd_column;
            cmd_request_id = mem_rd_request_id;
        end
    end

    // Playback FSM. busy and done are registered from the next state, so
    // each one follows its state with no combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            end_cycle_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            end_cycle_reg <= sched_max_cycle;
                            ptr_reg       <= '0;
                            state_reg     <= ST_PRIME;
                            busy_reg      <= 1'b1;
                        end
                    end
                    ST_PRIME: begin
                        state_reg <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (xfer) begin
                            if (at_end) begin
                                state_reg <= ST_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                ptr_reg <= ptr_reg + PTR_ONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SCHED_PLAYER_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

    // One saturating counter per tracked command type:
    // index 0 = ACT, index 1 = RD, index 2 = PRE.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [CMD_WIDTH-1:0]  match_type;
            logic [STAT_WIDTH-1:0] count_reg;

            assign match_type = (gi == 0) ? CMD_ACT :
                                (gi == 1) ? CMD_RD  : CMD_PRE;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (start_ok) begin
                    count_reg <= '0;
                end else if (xfer && (cmd_type == match_type) && (count_reg != '1)) begin
                    count_reg <= count_reg + STAT_ONE;
                end
            end
        end
    endgenerate

    assign act_count = g_stat[0].count_reg;
    assign rd_count  = g_stat[1].count_reg;
    assign pre_count = g_stat[2].count_reg;
`else
    // start_ok only feeds the statistics counters.
    logic unused_stats;
    assign unused_stats = start_ok;

    assign act_count = '0;
    assign rd_count  = '0;
    assign pre_count = '0;
`endif

endmodule

// File: doc/schedule_player.md
# schedule_player

Replays a completed DRAM command schedule out of `schedule_memory`, one schedule slot per transfer, from cycle 0 through the captured `max_cycle`. It drives the memory's synchronous read address, absorbs its one-cycle read latency, and presents each slot on a valid/ready command port toward the PHY/command-bus driver. PHY back-pressure stretches the timeline but keeps relative command spacing, because every slot is delivered, DESELECT included.

## Interface
Parameters:
- `STAT_WIDTH`, 16, width of each per-type statistics counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins playback. Ignored unless in IDLE.
- `abort`  in  1  synchronous abort; highest priority.
- `sched_max_cycle`  in  `CYCLE_WIDTH`  last populated slot, from `schedule_memory.max_cycle`.
- `mem_rd_cycle`  out  `CYCLE_WIDTH`  read address to `schedule_memory.rd_cycle` (combinational).
- `mem_rd_cmd_type`, `mem_rd_bank_group`, `mem_rd_bank`, `mem_rd_row`, `mem_rd_column`, `mem_rd_request_id`  in  widths from `dram_scheduler_types.vh`  registered read data from memory.
- `cmd_valid`  out  1  slot presented.
- `cmd_ready`  in  1  PHY accepts the slot.
- `cmd_cycle`  out  `CYCLE_WIDTH`  schedule index of the presented slot.
- `cmd_type`, `cmd_bank_group`, `cmd_bank`, `cmd_row`, `cmd_column`, `cmd_request_id`  out  same widths  slot payload.
- `busy`  out  1  high in PRIME or PLAY.
- `done`  out  1  one-cycle pulse on normal completion.
- `act_count`, `rd_count`, `pre_count`  out  `STAT_WIDTH`  statistics (see Configuration).

## Operation
- State machine with states IDLE, PRIME, PLAY, DONE. Registers: `ptr` (`CYCLE_WIDTH`) and `end_cycle` (`CYCLE_WIDTH`).
- IDLE: `mem_rd_cycle`=0. On `start`: `end_cycle`<=`sched_max_cycle`, `ptr`<=0, go to PRIME.
- PRIME: lasts one cycle, with `mem_rd_cycle`=0. Go to PLAY. On PLAY entry, memory output holds `mem[0]`.
- PLAY: `cmd_valid`=1. Payload passes combinationally from the `mem_rd_*` inputs. `cmd_cycle`=`ptr`.
- Transfer occurs when `cmd_valid & cmd_ready`.
  - Transfer with `ptr`!=`end_cycle`: `mem_rd_cycle`=`ptr+1`, and `ptr` increments.
  - No transfer: `mem_rd_cycle`=`ptr`, so the memory re-reads the same slot and the payload stays stable.
  - Transfer with `ptr`==`end_cycle`: `mem_rd_cycle`=`ptr` (no increment, no wrap), then go to DONE.
- DONE: lasts one cycle with `done`=1, then go to IDLE.
- Outside PLAY: `cmd_valid`=0, `cmd_type`=`CMD_DESELECT`, all other payload fields 0, `cmd_cycle`=0.
- `abort`, from any state: next state is IDLE, with no `done`. In the abort cycle, `cmd_valid` is forced to 0 combinationally, so no transfer happens. Counters hold their values.
- `start` outside IDLE is ignored. `start` and `abort` in the same cycle: abort wins and the FSM stays in IDLE.
- `sched_max_cycle`=0: exactly one slot (cycle 0) is played.
- `sched_max_cycle`=2^`CYCLE_WIDTH`-1: all slots are played and `ptr` never wraps.
- Changes to `sched_max_cycle` after `start` have no effect; the value is captured in `end_cycle`.

## Timing
- Reset values: state IDLE, `ptr`=0, `end_cycle`=0, `cmd_valid`=0, `cmd_type`=`CMD_DESELECT`, all other payload fields 0, `busy`=0, `done`=0, counters 0.
- With `start` high in cycle T: PRIME in T+1, first `cmd_valid` in T+2.
- With `cmd_ready` held high, slot k is presented in T+2+k. `done` asserts in T+3+`end_cycle`.
- Each stalled cycle delays all later slots by exactly one cycle.
- `busy` is registered from state and is high T+1 through the last PLAY cycle.

## Configuration
- Macro `SCHED_PLAYER_STATS_EN`.
- Defined:
  - `act_count`, `rd_count` and `pre_count` count transfers whose `cmd_type` equals `CMD_ACT`, `CMD_RD` or `CMD_PRE` respectively.
  - All three clear to 0 on an accepted `start`.
  - Each saturates at 2^`STAT_WIDTH`-1.
- Undefined: the counter ports remain but are tied to 0, and no counter flops exist.

## Test plan
- Schedule ACT@0, RD@3, PRE@5, `max_cycle`=5, `cmd_ready`=1, `start`@T -> six transfers T+2..T+7 with `cmd_cycle` 0..5, types ACT, DES, DES, RD, DES, PRE; `done` pulses at T+8.
- Same schedule with `cmd_ready`=0 for 3 cycles while slot 3 is presented -> slot 3 is held stable for 4 cycles, `mem_rd_cycle` stays 3, slot 4 follows immediately after acceptance, `done` at T+11.
- `max_cycle`=0 with ACT@0 -> one transfer at T+2 and `done` at T+3; `mem_rd_cycle` never exceeds 0.
- `abort` at T+4 of a 6-slot run -> `cmd_valid` low at T+4, IDLE at T+5, no `done`, `busy`=0; a re-`start` replays from slot 0.
- `start` pulsed during PLAY, and `rst_n` dropped mid-PLAY -> the start is ignored; on reset all outputs take their reset values immediately (asynchronous).
- `SCHED_PLAYER_STATS_EN` defined, schedule of 2 ACT, 3 RD, 1 PRE -> counts 2/3/1 at `done`; counters clear on the next `start`. Undefined -> counters read 0.
